// File: rtl/bayer_pkg.sv
//------------------------------------------------------------------------------
// Module   : bayer_pkg
// Brief    : Shared definitions for the Bayer demosaic capture path: pattern
//            encodings, site-colour enum and interpolation sum-width helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bayer_pkg;

  // Bayer phase encodings as seen on cfg_pattern (colour of pixel (0,0) and
  // its right-hand neighbour)
  localparam logic [1:0] c_PAT_RGGB = 2'd0;
  localparam logic [1:0] c_PAT_GRBG = 2'd1;
  localparam logic [1:0] c_PAT_GBRG = 2'd2;
  localparam logic [1:0] c_PAT_BGGR = 2'd3;

  // Site colour at a window centre. The encoding equals pattern XOR
  // {row parity, col parity}, so the site is a plain XOR of those bits.
  typedef enum logic [1:0] {
    SITE_R  = 2'd0,
    SITE_GR = 2'd1,
    SITE_GB = 2'd2,
    SITE_B  = 2'd3
  } site_t;

  // Width of a two-sample sum: one carry bit above the sample width
  function automatic int sum2_width(input int pix_w);
    return pix_w + 1;
  endfunction

  // Width of a four-sample sum: two carry bits; (sum + 2) still fits
  function automatic int sum4_width(input int pix_w);
    return pix_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bayer_linebuf_2row.sv
//------------------------------------------------------------------------------
// Module   : bayer_linebuf_2row
// Brief    : Two-row line buffer. Rows are stored ping-pong by row parity in
//            two single-port read-first RAMs with one cycle of read latency.
//            tap_prev returns row r-1 and tap_prev2 row r-2 at the column
//            address presented one cycle earlier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bayer_linebuf_2row #(
  parameter int PIX_W     = 8,
  parameter int IMG_WIDTH = 1280
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         row_sel,
  input  logic [$clog2(IMG_WIDTH)-1:0] addr,
  input  logic [PIX_W-1:0]             wr_data,
  output logic [PIX_W-1:0]             tap_prev,
  output logic [PIX_W-1:0]             tap_prev2
);

  logic [PIX_W-1:0] r_mem0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_mem1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_rd0;
  logic [PIX_W-1:0] r_rd1;
  logic             r_sel;

  // Bank 0: read-first port, written while the live row is even
  always_ff @(posedge clk) begin
    if (en) begin
      r_rd0 <= r_mem0[addr];
      if (!row_sel) r_mem0[addr] <= wr_data;
    end
  end

  // Bank 1: read-first port, written while the live row is odd
  always_ff @(posedge clk) begin
    if (en) begin
      r_rd1 <= r_mem1[addr];
      if (row_sel) r_mem1[addr] <= wr_data;
    end
  end

  // Remember which bank held the live row so the taps can be reordered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sel <= 1'b0;
    else if (en) r_sel <= row_sel;
  end

  // The bank being overwritten holds row r-2; the other holds row r-1
  assign tap_prev  = r_sel ? r_rd0 : r_rd1;
  assign tap_prev2 = r_sel ? r_rd1 : r_rd0;

endmodule

`default_nettype wire

// File: rtl/bayer_demosaic.sv
//------------------------------------------------------------------------------
// Module   : bayer_demosaic
// Brief    : DVP Bayer capture and bilinear demosaic. Tracks frame/line
//            position, forms a 3x3 window from a two-row line buffer and emits
//            interior RGB pixels with SOF/EOL markers, two cycles after input.
//            Optional line-length checking: BAYER_DEMOSAIC_SIZE_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bayer_demosaic
  import bayer_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int IMG_WIDTH = 1280
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_vsync,
  input  logic               in_hsync,
  input  logic [1:0]         cfg_pattern,
  output logic [3*PIX_W-1:0] out_data,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_vsync,
  output logic               err_size
);

  localparam int c_COL_W  = $clog2(IMG_WIDTH + 2);
  localparam int c_ADDR_W = $clog2(IMG_WIDTH);
  localparam int c_ROW_W  = 16;
  localparam int c_S2_W   = sum2_width(PIX_W);
  localparam int c_S4_W   = sum4_width(PIX_W);
  localparam logic [c_COL_W-1:0] c_WIDTH    = c_COL_W'(IMG_WIDTH);
  localparam logic [c_COL_W-1:0] c_COL_MAX  = c_COL_W'(IMG_WIDTH + 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_MAX  = '1;

  logic               r_vs_d1, r_vs_d2, r_hs_d, r_locked;
  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] r_col;
  logic [1:0]         r_pat;
  logic               w_vs_rise, w_hs_fall, w_accept, w_write;
  logic [c_ROW_W-1:0] w_row;
  logic [c_COL_W-1:0] w_col;
  logic [1:0]         w_pat;

  // A frame restart takes priority: the coincident pixel becomes (0,0)
  assign w_vs_rise = in_vsync & ~r_vs_d1;
  assign w_hs_fall = ~in_hsync & r_hs_d;
  assign w_accept  = in_hsync & (r_locked | w_vs_rise);
  assign w_row     = w_vs_rise ? '0 : r_row;
  assign w_col     = w_vs_rise ? '0 : r_col;
  assign w_pat     = w_vs_rise ? cfg_pattern : r_pat;
  assign w_write   = w_accept & (w_col < c_WIDTH);
  assign out_vsync = r_vs_d2;

  // Frame/line position tracking, pattern latch and lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_d1 <= 1'b0; r_vs_d2 <= 1'b0; r_hs_d <= 1'b0; r_locked <= 1'b0;
      r_row <= '0; r_col <= '0; r_pat <= 2'd0;
    end else begin
      r_vs_d1 <= in_vsync;
      r_vs_d2 <= r_vs_d1;
      r_hs_d  <= in_hsync;
      if (w_vs_rise) begin
        r_row    <= '0;
        r_pat    <= cfg_pattern;
        r_locked <= 1'b1;
        r_col    <= in_hsync ? c_COL_W'(1) : '0;
      end else if (w_hs_fall) begin
        r_col <= '0;
        if (r_col != '0 && r_row != c_ROW_MAX) r_row <= r_row + 1'b1;
      end else if (w_accept && r_col != c_COL_MAX) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  logic               r_s1_valid, r_s1_row_ge2, r_s1_row_eq2, r_s1_row_odd;
  logic [PIX_W-1:0]   r_s1_pix;
  logic [c_COL_W-1:0] r_s1_col;
  logic [1:0]         r_s1_pat;

  // Stage 1 register: live pixel and its position, aligned with the RAM taps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0; r_s1_row_ge2 <= 1'b0; r_s1_row_eq2 <= 1'b0;
      r_s1_row_odd <= 1'b0; r_s1_pix <= '0; r_s1_col <= '0; r_s1_pat <= 2'd0;
    end else begin
      r_s1_valid <= w_write;
      if (w_write) begin
        r_s1_pix     <= in_data;
        r_s1_col     <= w_col;
        r_s1_row_ge2 <= (w_row >= c_ROW_W'(2));
        r_s1_row_eq2 <= (w_row == c_ROW_W'(2));
        r_s1_row_odd <= w_row[0];
        r_s1_pat     <= w_pat;
      end
    end
  end

  logic [PIX_W-1:0] w_tap1, w_tap2;

  bayer_linebuf_2row #(
    .PIX_W     (PIX_W),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .en        (w_write),
    .row_sel   (w_row[0]),
    .addr      (w_col[c_ADDR_W-1:0]),
    .wr_data   (in_data),
    .tap_prev  (w_tap1),
    .tap_prev2 (w_tap2)
  );

  logic [PIX_W-1:0] r_top1, r_top2, r_mid1, r_mid2, r_bot1, r_bot2;

  // Two-deep column shift registers holding columns c-1 and c-2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top1 <= '0; r_top2 <= '0; r_mid1 <= '0;
      r_mid2 <= '0; r_bot1 <= '0; r_bot2 <= '0;
    end else if (r_s1_valid) begin
      r_top1 <= w_tap2;   r_top2 <= r_top1;
      r_mid1 <= w_tap1;   r_mid2 <= r_mid1;
      r_bot1 <= r_s1_pix; r_bot2 <= r_bot1;
    end
  end

  // Window: column c is {w_tap2, w_tap1, r_s1_pix}; centre is r_mid1
  logic [c_S4_W-1:0] w_sum_cross, w_sum_diag;
  logic [c_S2_W-1:0] w_sum_ns, w_sum_we;
  logic [PIX_W-1:0]  w_avg_cross, w_avg_diag, w_avg_ns, w_avg_we;
  logic [PIX_W-1:0]  w_r, w_g, w_b;
  logic              w_emit, w_sof, w_eol;
  site_t             w_site;

  assign w_sum_cross = c_S4_W'(r_top1) + c_S4_W'(r_bot1) + c_S4_W'(r_mid2) + c_S4_W'(w_tap1);
  assign w_sum_diag  = c_S4_W'(r_top2) + c_S4_W'(w_tap2) + c_S4_W'(r_bot2) + c_S4_W'(r_s1_pix);
  assign w_sum_ns    = c_S2_W'(r_top1) + c_S2_W'(r_bot1);
  assign w_sum_we    = c_S2_W'(r_mid2) + c_S2_W'(w_tap1);
  assign w_avg_cross = PIX_W'((w_sum_cross + c_S4_W'(2)) >> 2);
  assign w_avg_diag  = PIX_W'((w_sum_diag + c_S4_W'(2)) >> 2);
  assign w_avg_ns    = PIX_W'((w_sum_ns + c_S2_W'(1)) >> 1);
  assign w_avg_we    = PIX_W'((w_sum_we + c_S2_W'(1)) >> 1);

  // Centre is (r-1, c-1), so its parities are the inverted live parities
  assign w_site = site_t'(r_s1_pat ^ {~r_s1_row_odd, ~r_s1_col[0]});
  assign w_emit = r_s1_valid & r_s1_row_ge2 & (r_s1_col >= c_COL_W'(2));
  assign w_sof  = w_emit & r_s1_row_eq2 & (r_s1_col == c_COL_W'(2));
  assign w_eol  = w_emit & (r_s1_col == c_COL_LAST);

  // Per-site selection of the three colour components
  always_comb begin
    w_r = r_mid1;
    w_g = w_avg_cross;
    w_b = w_avg_diag;
    case (w_site)
      SITE_R:  begin w_r = r_mid1;     w_g = w_avg_cross; w_b = w_avg_diag; end
      SITE_B:  begin w_r = w_avg_diag; w_g = w_avg_cross; w_b = r_mid1;     end
      SITE_GR: begin w_r = w_avg_we;   w_g = r_mid1;      w_b = w_avg_ns;   end
      SITE_GB: begin w_r = w_avg_ns;   w_g = r_mid1;      w_b = w_avg_we;   end
      default: ;
    endcase
  end

  // Stage 2: output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; out_sof <= 1'b0; out_eol <= 1'b0; out_data <= '0;
    end else begin
      out_valid <= w_emit;
      out_sof   <= w_sof;
      out_eol   <= w_eol;
      if (w_emit) out_data <= {w_r, w_g, w_b};
    end
  end

`ifdef BAYER_DEMOSAIC_SIZE_CHECK_EN
  // Sticky line-length error, cleared at the next frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_size <= 1'b0;
    else if (w_vs_rise) err_size <= 1'b0;
    else if (w_hs_fall && r_locked && r_col != c_WIDTH) err_size <= 1'b1;
  end
`else
  assign err_size = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/bayer_demosaic.md
# bayer_demosaic

Parametrised DVP-to-RGB capture and demosaic stage for Bayer-pattern CMOS sensors. It sits between the sensor pins and the video-out/VDMA path. It tracks frame and line position, buffers two lines, forms a 3×3 window, and emits bilinear-interpolated RGB pixels with frame and line markers. It generalises the fixed 8-bit, 1280-wide, single-pattern capture path with configurable pixel width, line length and runtime Bayer phase, proper rounding, and SOF/EOL markers.

## Interface
- PIX_W, 8: bits per raw/colour sample.
- IMG_WIDTH, 1280: active pixels per input line; also the line-buffer depth. Minimum 4.
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  PIX_W  raw Bayer sample.
- in_vsync  in  1  active-high; rising edge marks frame start.
- in_hsync  in  1  active-high; qualifies in_data (href).
- cfg_pattern  in  2  Bayer phase: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
- out_data  out  3*PIX_W  {R,G,B}, R in the MSBs.
- out_valid  out  1  out_data is valid.
- out_sof  out  1  first valid pixel of a frame.
- out_eol  out  1  last valid pixel of a line.
- out_vsync  out  1  in_vsync delayed by 2 cycles.
- err_size  out  1  sticky line-length error (see Configuration).

## Operation
- **Frame start.** On the in_vsync rising edge:
  - row counter ← 0;
  - cfg_pattern is latched; changes mid-frame are ignored;
  - `locked` ← 1.
- **Pixel acceptance.** A pixel is accepted on each cycle with in_hsync=1.
  - Column counter increments per accepted pixel.
  - On the in_hsync falling edge the column counter ← 0 and, if at least one pixel was accepted, the row counter increments (saturating).
  - Pixels at column ≥ IMG_WIDTH are discarded: not written, not output.
- **Line buffer.** Holds the previous two rows. The 3×3 window is formed from two row taps plus the live row through 2-deep column shift registers.
- **Output region.** Only window centres in the interior are output. Input pixel (r,c) with r≥2 and 2≤c≤IMG_WIDTH-1 produces centre (r-1,c-1). Output frame size is (IMG_WIDTH-2)×(H-2). Edge rows and columns are dropped.
- **Site colour.** Determined from the latched pattern XOR the centre (row, col) parity.
- **Interpolation.** All averages use round-half-up: avg2=(a+b+1)>>1, avg4=(a+b+c+d+2)>>2. Intermediate sums are PIX_W+2 bits; no overflow or saturation is possible.
  - R site: R=c, G=avg4(N,S,E,W), B=avg4(diagonals).
  - B site: mirror of the R site.
  - G on an R row: R=avg2(W,E), B=avg2(N,S).
  - G on a B row: R=avg2(N,S), B=avg2(W,E).
- **Markers.**
  - out_sof accompanies the first output of each frame: centre (1,1).
  - out_eol accompanies centre column IMG_WIDTH-2.
  - A short line (in_hsync falls before column IMG_WIDTH-1) produces no out_eol.
- **Lock.** After reset, `locked`=0 and no output is produced until the first in_vsync rising edge.

## Timing
- Reset values: out_data=0, out_valid=0, out_sof=0, out_eol=0, out_vsync=0, err_size=0, all counters 0, latched pattern=0, locked=0.
- Latency: out_valid/out_data/out_sof/out_eol appear exactly 2 cycles after the cycle in which the producing pixel is accepted.
  - Stage 1: window and sums.
  - Stage 2: rounding and output register.
- There is no backpressure. Output throughput equals input throughput, one pixel per cycle.
- Gaps in in_hsync inside a line are not supported. A falling edge ends the line.
- in_vsync rising on the same cycle as in_hsync=1: the frame restart takes priority. That pixel is accepted as row 0, col 0 of the new frame.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). Pipeline contents are discarded.

## Configuration
- `BAYER_DEMOSAIC_SIZE_CHECK_EN` defined:
  - each line's accepted-pixel count is compared with IMG_WIDTH at the in_hsync falling edge;
  - a mismatch sets err_size;
  - err_size stays set until the next in_vsync rising edge, which clears it;
  - output is unaffected.
- Macro undefined: err_size is tied to 0 and the line-length logic is not built.

## Structure
- Shared package `bayer_pkg` holds:
  - the pattern encoding constants (RGGB/GRBG/GBRG/BGGR);
  - the site-colour enum (SITE_R, SITE_GR, SITE_GB, SITE_B);
  - the helpers for avg2/avg4 widths.
- Sub-module `bayer_linebuf_2row`: two IMG_WIDTH×PIX_W single-port-per-row RAMs, written at the column address, with 1-cycle read latency. It is inferable as BRAM.

## Test plan
- Flat field, PIX_W=8, IMG_WIDTH=8, 6 lines of value 100, RGGB → 4 lines of 6 outputs, each {100,100,100}; out_sof once; out_eol 4 times.
- Pure RGGB field (R=200, G=100, B=50) for each cfg_pattern with matching data → every output is {200,100,50}.
- Rounding: G neighbours of an R site 1,2,2,2 → G=2; E/W = 3,4 at a G site → R or B=4.
- cfg_pattern changed mid-frame → no change in output colouring until after the next in_vsync rising edge.
- rst pulsed low mid-frame → outputs 0 immediately; no out_valid until a new in_vsync rising edge, then normal output from that frame.
- Macro on: a line of 5 pixels with IMG_WIDTH=8 → err_size=1 from that line's end until the next frame start. Macro off: err_size stays 0.
